// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready word capture, internal baud timing, start/data(LSB first)/[parity]/stop framing.
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects the sense); undefined means no parity.
module uart_tx_frame #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 serial_q, serial_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 baud_wrap;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_wrap ? '0 : baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (tx_valid && ready_q) begin
                    state_d  = S_START;
                    shift_d  = tx_data;
                    bit_d    = '0;
                    serial_d = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ PARITY_ODD[0];
`endif
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                    bit_d    = '0;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d  = S_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = S_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        // serial_d mirrors the bit that becomes shift_d[0]
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                        bit_d    = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d  = S_STOP;
                    serial_d = 1'b1;
                    bit_d    = '0;
                end
            end
`endif
            S_STOP: begin
                if (baud_wrap) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d  = S_IDLE;
                        bit_d    = '0;
                        serial_d = 1'b1;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                baud_d   = '0;
                bit_d    = '0;
                serial_d = 1'b1;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Payload registers carry no reset; they are only consumed after a fresh capture.
    always_ff @(posedge clk) begin
        shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    assign tx_ready   = ready_q;
    assign busy       = busy_q;
    assign serial_out = serial_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: directed words are queued as expected frames and a
// line-decoding monitor per instance compares every bit period, frame length and completion.
module tb_uart_tx_frame;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBA = 1 + 8 + P + 1;   // frame bits, instance A (8 data, 1 stop, even)
    localparam int NBB = 1 + 5 + P + 2;   // frame bits, instance B (5 data, 2 stop, odd)
    localparam int FA  = NBA * CPB;       // 40 without parity, 44 with
    localparam int FB  = NBB * CPB;       // 32 without parity, 36 with

    typedef struct {
        int data;
        bit abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_ser, a_busy, a_done;
    logic [4:0] b_data;
    logic       b_valid, b_ready, b_ser, b_busy, b_done;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t qa[$];
    int   qb[$];
    int   starts_a[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
        .serial_out(a_ser), .busy(a_busy), .tx_done(a_done));

    uart_tx_frame #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
        .serial_out(b_ser), .busy(b_busy), .tx_done(b_done));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected line level for each bit period of a frame (bit 0 = start).
    function automatic logic [15:0] frame(input int data, input int nd, input int podd);
        logic [15:0] f;
        logic        p;
        f = '1;
        f[0] = 1'b0;
        p = podd[0];
        for (int i = 0; i < nd; i++) begin
            f[1 + i] = data[i];
            p ^= data[i];
        end
        if (P == 1) f[1 + nd] = p;
        return f;
    endfunction

    // Monitor for instance A
    initial begin : mon_a
        logic prev;
        bit   after_done;
        prev = 1'b1;
        after_done = 1'b0;
        forever begin
            @(negedge clk);
            if (after_done && !rst) check("a_done_one_cycle", a_done, 1'b0);
            after_done = 1'b0;
            if (!rst && prev && !a_ser) begin : frame_a
                exp_t        e;
                logic [15:0] f;
                bit          aborted, ok;
                int          t0;
                t0 = cyc;
                starts_a.push_back(t0);
                if (qa.size() == 0) begin
                    check("a_frame_expected", qa.size(), 1);
                    e.data = 0;
                    e.abort = 1'b0;
                end else begin
                    e = qa.pop_front();
                end
                f = frame(e.data, 8, 0);
                aborted = 1'b0;
                for (int b = 0; b < NBA && !aborted; b++) begin
                    ok = 1'b1;
                    for (int c = 0; c < CPB && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        else if (a_ser !== f[b] || a_busy !== 1'b1 || a_ready !== 1'b0 || a_done !== 1'b0)
                            ok = 1'b0;
                    end
                    if (!aborted) check($sformatf("a_word%02h_bit%0d", e.data, b), ok, 1'b1);
                end
                if (aborted) begin
                    check("a_abort_expected", e.abort, 1'b1);
                end else begin
                    if (e.abort) check("a_abort_seen", 1'b0, 1'b1);
                    @(negedge clk);
                    check("a_frame_len", cyc - t0, FA);
                    check("a_done_pulse", a_done, 1'b1);
                    check("a_ready_at_end", a_ready, 1'b1);
                    check("a_busy_at_end", a_busy, 1'b0);
                    check("a_gap_line_high", a_ser, 1'b1);
                    after_done = 1'b1;
                end
            end
            prev = a_ser;
        end
    end

    // Monitor for instance B
    initial begin : mon_b
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !b_ser) begin : frame_b
                logic [15:0] f;
                bit          ok;
                int          d, t0;
                t0 = cyc;
                if (qb.size() == 0) begin
                    check("b_frame_expected", qb.size(), 1);
                    d = 0;
                end else begin
                    d = qb.pop_front();
                end
                f = frame(d, 5, 1);
                for (int b = 0; b < NBB; b++) begin
                    ok = 1'b1;
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (b_ser !== f[b] || b_busy !== 1'b1 || b_ready !== 1'b0 || b_done !== 1'b0)
                            ok = 1'b0;
                    end
                    check($sformatf("b_word%02h_bit%0d", d, b), ok, 1'b1);
                end
                @(negedge clk);
                check("b_frame_len", cyc - t0, FB);
                check("b_done_pulse", b_done, 1'b1);
                check("b_ready_at_end", b_ready, 1'b1);
            end
            prev = b_ser;
        end
    end

    task automatic wait_ready_a();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (a_ready !== 1'b1 && n < 500);
        if (a_ready !== 1'b1) check("a_ready_timeout", a_ready, 1'b1);
    endtask

    task automatic wait_ready_b();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (b_ready !== 1'b1 && n < 500);
        if (b_ready !== 1'b1) check("b_ready_timeout", b_ready, 1'b1);
    endtask

    task automatic send_a(input logic [7:0] d, input bit hold, input bit abort);
        exp_t e;
        wait_ready_a();
        a_data = d;
        a_valid = 1'b1;
        e.data = int'(d);
        e.abort = abort;
        qa.push_back(e);
        @(posedge clk);
        if (!hold) begin
            @(negedge clk);
            a_valid = 1'b0;
        end
    endtask

    task automatic send_b(input logic [4:0] d);
        wait_ready_b();
        b_data = d;
        b_valid = 1'b1;
        qb.push_back(int'(d));
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int sz, seen;
        a_data = '0;
        a_valid = 1'b0;
        b_data = '0;
        b_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial_out", a_ser, 1'b1);
        check("rst_tx_ready", a_ready, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_tx_done", a_done, 1'b0);
        check("rst_b_ready", b_ready, 1'b1);
        #2 rst = 1'b0;

        // Alternating pattern, then a word exercising the parity bit on both instances
        send_a(8'h55, 1'b0, 1'b0);
        send_a(8'h07, 1'b0, 1'b0);
        send_b(5'h07);

        // Back-to-back with tx_valid held high
        send_a(8'hA5, 1'b1, 1'b0);
        send_a(8'h3C, 1'b0, 1'b0);
        wait_ready_a();
        repeat (2) @(negedge clk);
        sz = starts_a.size();
        if (sz >= 2) check("b2b_start_spacing", starts_a[sz-1] - starts_a[sz-2], FA + 1);
        else check("b2b_start_count", sz, 2);

        // Word offered mid-frame must be dropped
        send_a(8'h00, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        check("busy_ready_low", a_ready, 1'b0);
        a_data = 8'hFF;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        wait_ready_a();
        repeat (8) @(negedge clk);

        // Asynchronous reset during data bit 3
        send_a(8'h96, 1'b0, 1'b1);
        repeat (17) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_serial_out", a_ser, 1'b1);
        check("midrst_tx_ready", a_ready, 1'b1);
        check("midrst_busy", a_busy, 1'b0);
        check("midrst_tx_done", a_done, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (a_done !== 1'b0) seen++;
        end
        check("midrst_no_done", seen, 0);
        send_a(8'h5A, 1'b0, 1'b0);

        // Two stop bits, five data bits
        send_b(5'h1F);
        send_b(5'h0A);

        wait_ready_a();
        wait_ready_b();
        repeat (4) @(negedge clk);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
